// File: rtl/lane_sum_drain.sv
// Serialises one packed vector of lane results into a lane-per-beat stream.
// Each beat carries its lane index, a last flag and a running sum.
package mypkg;
  parameter int WIDTH = 4;
  typedef logic [WIDTH-1:0] mytype;
endpackage

module lane_sum_drain #(
  parameter int WIDTH = mypkg::WIDTH,
  parameter int LANES = 16,
  parameter int IDXW  = $clog2(LANES),
  parameter int SUMW  = WIDTH + IDXW
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic [IDXW-1:0]        out_idx,
  output logic                   out_last,
  output logic [SUMW-1:0]        out_sum
);

  typedef enum logic {IDLE, DRAIN} state_t;

  state_t                 r_state;
  logic [LANES*WIDTH-1:0] r_buf;
  logic [IDXW-1:0]        r_idx;
  logic [SUMW-1:0]        r_acc;

  logic [WIDTH-1:0]       w_lanes [LANES];
  logic [WIDTH-1:0]       w_lane;
  logic [SUMW-1:0]        w_sum;
  logic                   w_drain;
  logic                   w_last;
  logic                   w_accept;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    assign w_lanes[g] = r_buf[g*WIDTH +: WIDTH];
  end

  assign w_drain  = (r_state == DRAIN);
  assign w_lane   = w_lanes[r_idx];
  assign w_sum    = r_acc + {{(SUMW-WIDTH){1'b0}}, w_lane};
  assign w_last   = w_drain && (r_idx == IDXW'(LANES-1));
  assign w_accept = w_drain && out_ready;

  // Outputs are zeroed outside DRAIN so stale buffer contents never leak out.
  assign out_valid = w_drain;
  assign out_data  = w_drain ? w_lane : '0;
  assign out_idx   = w_drain ? r_idx  : '0;
  assign out_sum   = w_drain ? w_sum  : '0;
  assign out_last  = w_last;

  // The only combinational input-to-output path: lets a new vector be taken on the last beat.
  assign in_ready = rst_n && ((r_state == IDLE) || (w_last && out_ready));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_buf   <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_buf   <= in_data;
            r_idx   <= '0;
            r_acc   <= '0;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_accept) begin
            if (!w_last) begin
              r_idx <= r_idx + IDXW'(1);
              r_acc <= w_sum;
            end else if (in_valid) begin
              r_buf <= in_data;
              r_idx <= '0;
              r_acc <= '0;
            end else begin
              r_idx   <= '0;
              r_acc   <= '0;
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lane_sum_drain.sv
// Directed bench for lane_sum_drain: drain, max sum, backpressure, back-to-back,
// blocked input and reset mid-drain, all checked at the falling edge.
module tb_lane_sum_drain;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_data;
  logic [3:0]  out_idx;
  logic        out_last;
  logic [7:0]  out_sum;

  int checks   = 0;
  int failures = 0;
  logic [7:0] lastSum;

  localparam logic [63:0] VEC_SEQ  = 64'hFEDC_BA98_7654_3210;
  localparam logic [63:0] VEC_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] VEC_REV  = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] VEC_MIX  = 64'h0F1E_2D3C_4B5A_6978;

  lane_sum_drain dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .out_sum   (out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkBeat(input string name, input int i, input logic [3:0] lane, input logic [7:0] sum);
    checkOutput($sformatf("%s valid[%0d]", name, i), 64'(out_valid), 64'd1);
    checkOutput($sformatf("%s data[%0d]",  name, i), 64'(out_data),  64'(lane));
    checkOutput($sformatf("%s idx[%0d]",   name, i), 64'(out_idx),   64'(i));
    checkOutput($sformatf("%s last[%0d]",  name, i), 64'(out_last),  64'(i == 15));
    checkOutput($sformatf("%s sum[%0d]",   name, i), 64'(out_sum),   64'(sum));
  endtask

  // Called at a falling edge while IDLE; offers vec for one cycle.
  task automatic applyStimulus(input logic [63:0] vec, input string name);
    checkOutput({name, " idle valid"}, 64'(out_valid), 64'd0);
    checkOutput({name, " idle ready"}, 64'(in_ready),  64'd1);
    in_valid = 1'b1;
    in_data  = vec;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 64'hDEAD_BEEF_DEAD_BEEF;
  endtask

  // Called at the falling edge where lane 0 of vec is showing.
  // offerIdx>=0 offers nextVec from that beat on; resetIdx>=0 pulses reset there.
  task automatic runVector(input logic [63:0] vec, input string name, input int stallIdx,
                           input int offerIdx, input logic [63:0] nextVec, input int resetIdx);
    logic [7:0] sum;
    logic [3:0] lane;
    sum = 8'h00;
    for (int i = 0; i < 16; i++) begin
      lane = vec[i*4 +: 4];
      sum  = sum + {4'h0, lane};
      checkBeat(name, i, lane, sum);
      checkOutput($sformatf("%s in_ready[%0d]", name, i), 64'(in_ready), 64'(i == 15));
      lastSum = out_sum;
      if (i == offerIdx) begin
        in_valid = 1'b1;
        in_data  = nextVec;
      end
      if (i == resetIdx) begin
        #2 rst_n = 1'b0;
        #1;
        checkOutput({name, " rst valid"}, 64'(out_valid), 64'd0);
        checkOutput({name, " rst ready"}, 64'(in_ready),  64'd0);
        checkOutput({name, " rst data"},  64'(out_data),  64'd0);
        checkOutput({name, " rst sum"},   64'(out_sum),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput({name, " post-rst ready"}, 64'(in_ready), 64'd1);
        checkOutput({name, " post-rst valid"}, 64'(out_valid), 64'd0);
        return;
      end
      if (i == stallIdx) begin
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          checkBeat({name, " stall"}, i, lane, sum);
          checkOutput({name, " stall in_ready"}, 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    lastSum   = '0;
    @(negedge clk);
    checkOutput("reset out_valid", 64'(out_valid), 64'd0);
    checkOutput("reset in_ready",  64'(in_ready),  64'd0);
    checkOutput("reset out_data",  64'(out_data),  64'd0);
    checkOutput("reset out_idx",   64'(out_idx),   64'd0);
    checkOutput("reset out_last",  64'(out_last),  64'd0);
    checkOutput("reset out_sum",   64'(out_sum),   64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("release in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);

    applyStimulus(VEC_SEQ, "basic");
    runVector(VEC_SEQ, "basic", -1, -1, '0, -1);
    checkOutput("basic final sum", 64'(lastSum), 64'h78);

    applyStimulus(VEC_ONES, "maxsum");
    runVector(VEC_ONES, "maxsum", -1, -1, '0, -1);
    checkOutput("maxsum final sum", 64'(lastSum), 64'hF0);

    applyStimulus(VEC_SEQ, "bp");
    runVector(VEC_SEQ, "bp", 5, -1, '0, -1);

    applyStimulus(VEC_REV, "b2b");
    runVector(VEC_REV, "b2b A", -1, 0, VEC_MIX, -1);
    checkOutput("b2b lane0 sum", 64'(out_sum), 64'h08);
    runVector(VEC_MIX, "b2b B", -1, -1, '0, -1);

    applyStimulus(VEC_SEQ, "blocked");
    runVector(VEC_SEQ, "blocked", -1, 3, VEC_ONES, -1);
    checkOutput("blocked next lane0 sum", 64'(out_sum), 64'h0F);
    runVector(VEC_ONES, "blocked next", -1, -1, '0, -1);

    applyStimulus(VEC_SEQ, "rstmid");
    runVector(VEC_SEQ, "rstmid", -1, -1, '0, 7);
    applyStimulus(VEC_REV, "after rst");
    checkOutput("after rst lane0 sum", 64'(out_sum), 64'h0F);
    runVector(VEC_REV, "after rst", -1, -1, '0, -1);

    checkOutput("end idle valid", 64'(out_valid), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
